// File: rtl/tl_probe_seq.sv
// Probe sequencer: fans one probe job out over the B channel (one probe per cycle) and collects acks.
// Optional WAIT timeout is compiled in with TL_PROBE_TIMEOUT_EN.
module tl_probe_seq #(
  parameter int N_CLIENTS      = 4,
  parameter int ADDR_W         = 64,
  parameter int SOURCE_W       = 4,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CID_W          = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [ADDR_W-1:0]    req_address_i,
  input  logic [2:0]           req_param_i,
  input  logic [SOURCE_W-1:0]  req_source_i,
  input  logic [N_CLIENTS-1:0] req_mask_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [2:0]           b_opcode_o,
  output logic [2:0]           b_param_o,
  output logic [3:0]           b_size_o,
  output logic [SOURCE_W-1:0]  b_source_o,
  output logic [ADDR_W-1:0]    b_address_o,
  output logic [CID_W-1:0]     b_dest_o,
  input  logic                 ack_valid_i,
  input  logic [CID_W-1:0]     ack_client_i,
  input  logic                 ack_data_i,
  output logic                 done_valid_o,
  input  logic                 done_ready_i,
  output logic [N_CLIENTS-1:0] done_mask_o,
  output logic                 done_dirty_o,
  output logic                 done_timeout_o,
  output logic                 err_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [2:0]            param_q, param_d;
  logic [SOURCE_W-1:0]   source_q, source_d;
  logic [N_CLIENTS-1:0]  mask_q, mask_d;
  logic [N_CLIENTS-1:0]  issued_q, issued_d;
  logic [N_CLIENTS-1:0]  acked_q, acked_d;
  logic                  dirty_q, dirty_d;
  logic                  timeout_q, timeout_d;
  logic                  err_q, err_d;

  logic [N_CLIENTS-1:0]  pending, dest_oh, ack_oh;
  logic [CID_W-1:0]      dest;
  logic                  ack_hit, issuing, done_st;

`ifdef TL_PROBE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    pending = mask_q & ~issued_q;
    dest_oh = pending & (~pending + 1'b1);
    dest    = '0;
    ack_oh  = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (pending[i]) dest = CID_W'(i);
    end
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (ack_client_i == CID_W'(i)) ack_oh[i] = 1'b1;
    end
    issuing = (state_q == ISSUE);
    done_st = (state_q == DONE);
    // Acks only count for probes already on the wire and not yet answered.
    ack_hit = ack_valid_i && (state_q == ISSUE || state_q == WAIT) &&
              |(ack_oh & issued_q & ~acked_q);

    state_d   = state_q;
    addr_d    = addr_q;
    param_d   = param_q;
    source_d  = source_q;
    mask_d    = mask_q;
    issued_d  = issued_q;
    acked_d   = acked_q;
    dirty_d   = dirty_q;
    timeout_d = timeout_q;
    err_d     = err_q;
`ifdef TL_PROBE_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    if (ack_valid_i) begin
      if (ack_hit) begin
        acked_d = acked_q | ack_oh;
        dirty_d = dirty_q | ack_data_i;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: if (req_valid_i) begin
        addr_d    = req_address_i;
        param_d   = req_param_i;
        source_d  = req_source_i;
        mask_d    = req_mask_i;
        issued_d  = '0;
        acked_d   = '0;
        dirty_d   = 1'b0;
        timeout_d = 1'b0;
        state_d   = (req_mask_i == '0) ? DONE : ISSUE;
      end
      ISSUE: if (b_ready_i) begin
        issued_d = issued_q | dest_oh;
        if ((pending & ~dest_oh) == '0) begin
          state_d = (acked_q == mask_q) ? DONE : WAIT;
`ifdef TL_PROBE_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        if (acked_q == mask_q) begin
          state_d = DONE;
        end
`ifdef TL_PROBE_TIMEOUT_EN
        else if (ack_hit) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: if (done_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      param_q   <= '0;
      source_q  <= '0;
      mask_q    <= '0;
      issued_q  <= '0;
      acked_q   <= '0;
      dirty_q   <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef TL_PROBE_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      param_q   <= param_d;
      source_q  <= source_d;
      mask_q    <= mask_d;
      issued_q  <= issued_d;
      acked_q   <= acked_d;
      dirty_q   <= dirty_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
`ifdef TL_PROBE_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Data outputs are zeroed outside their valid state so nothing leaks while idle.
  assign req_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign b_valid_o    = issuing;
  assign b_opcode_o   = issuing ? 3'd6 : 3'd0;
  assign b_size_o     = issuing ? 4'd6 : 4'd0;
  assign b_param_o    = issuing ? param_q : '0;
  assign b_source_o   = issuing ? source_q : '0;
  assign b_address_o  = issuing ? addr_q : '0;
  assign b_dest_o     = issuing ? dest : '0;
  assign done_valid_o = done_st;
  assign done_mask_o  = done_st ? mask_q : '0;
  assign done_dirty_o = done_st & dirty_q;
`ifdef TL_PROBE_TIMEOUT_EN
  assign done_timeout_o = done_st & timeout_q;
`else
  assign done_timeout_o = 1'b0;
`endif
  assign err_o        = err_q;

endmodule

// File: tb/tb_tl_probe_seq.sv
// Directed and randomized bench for tl_probe_seq against a target-list / ack-set reference model.
module tb_tl_probe_seq;

  localparam int NC = 4;
  localparam int AW = 64;
  localparam int SW = 4;
  localparam int CW = 2;
`ifdef TL_PROBE_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1023;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid_i, req_ready_o;
  logic [AW-1:0] req_address_i;
  logic [2:0]    req_param_i;
  logic [SW-1:0] req_source_i;
  logic [NC-1:0] req_mask_i;
  logic          b_valid_o, b_ready_i;
  logic [2:0]    b_opcode_o, b_param_o;
  logic [3:0]    b_size_o;
  logic [SW-1:0] b_source_o;
  logic [AW-1:0] b_address_o;
  logic [CW-1:0] b_dest_o;
  logic          ack_valid_i, ack_data_i;
  logic [CW-1:0] ack_client_i;
  logic          done_valid_o, done_ready_i;
  logic [NC-1:0] done_mask_o;
  logic          done_dirty_o, done_timeout_o, err_o, busy_o;

  int n_chk = 0;
  int n_err = 0;
  logic exp_err;
  logic [AW-1:0] cur_addr;
  logic [2:0]    cur_param;
  logic [SW-1:0] cur_src;

  tl_probe_seq #(.N_CLIENTS(NC), .ADDR_W(AW), .SOURCE_W(SW), .TIMEOUT_CYCLES(TMO), .CID_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_address_i(req_address_i),
    .req_param_i(req_param_i), .req_source_i(req_source_i), .req_mask_i(req_mask_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_opcode_o(b_opcode_o), .b_param_o(b_param_o),
    .b_size_o(b_size_o), .b_source_o(b_source_o), .b_address_o(b_address_o), .b_dest_o(b_dest_o),
    .ack_valid_i(ack_valid_i), .ack_client_i(ack_client_i), .ack_data_i(ack_data_i),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i), .done_mask_o(done_mask_o),
    .done_dirty_o(done_dirty_o), .done_timeout_o(done_timeout_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [NC-1:0] m, input logic [2:0] p, input logic [SW-1:0] s,
                          input logic [AW-1:0] a);
    cur_addr = a; cur_param = p; cur_src = s;
    chk("req_ready_idle", req_ready_o, 1'b1);
    req_valid_i = 1'b1; req_mask_i = m; req_param_i = p; req_source_i = s; req_address_i = a;
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic chk_probe(input string tag, input int dest);
    chk({tag, "_bvld"}, b_valid_o, 1'b1);
    chk({tag, "_dest"}, b_dest_o, dest);
    chk({tag, "_op"}, b_opcode_o, 3'd6);
    chk({tag, "_size"}, b_size_o, 4'd6);
    chk({tag, "_fields"}, {b_param_o, b_source_o, b_address_o[56:0]},
        {cur_param, cur_src, cur_addr[56:0]});
  endtask

  task automatic send_ack(input int c, input logic d);
    ack_valid_i = 1'b1; ack_client_i = CW'(c); ack_data_i = d;
    step();
    ack_valid_i = 1'b0; ack_data_i = 1'b0;
  endtask

  task automatic finish_done(input string tag, input logic [NC-1:0] m, input logic dirty,
                             input logic tmo);
    int n = 0;
    while (!done_valid_o && n < 60) begin step(); n++; end
    chk({tag, "_done_vld"}, done_valid_o, 1'b1);
    chk({tag, "_done_mask"}, done_mask_o, m);
    chk({tag, "_dirty"}, done_dirty_o, dirty);
    chk({tag, "_tmo"}, done_timeout_o, tmo);
    chk({tag, "_err"}, err_o, exp_err);
    chk({tag, "_no_b"}, b_valid_o, 1'b0);
    done_ready_i = 1'b1;
    step();
    done_ready_i = 1'b0;
    chk({tag, "_back_idle"}, {req_ready_o, busy_o, done_valid_o}, 3'b100);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [NC-1:0] m;
    logic          exp_dirty;
    int            tq[$];
    int            al[$];
    int            n, idx, c, guard;
    logic          br, d;

    rst = 1'b1; req_valid_i = 0; req_address_i = '0; req_param_i = '0; req_source_i = '0;
    req_mask_i = '0; b_ready_i = 0; ack_valid_i = 0; ack_client_i = '0; ack_data_i = 0;
    done_ready_i = 0; exp_err = 1'b0;
    #1;
    chk("rst_outputs", {req_ready_o, busy_o, b_valid_o, done_valid_o, err_o, done_timeout_o},
        6'b100000);
    chk("rst_data", {b_opcode_o, b_size_o, b_dest_o, done_mask_o}, '0);
    step(); step();
    rst = 1'b0;
    step();

    // Three targets, back-to-back probes, acks out of order, clean data.
    b_ready_i = 1'b1;
    send_req(4'b1011, 3'd2, 4'd5, 64'hDEAD_BEEF_0000_1240);
    chk_probe("a_p0", 0);
    step(); chk_probe("a_p1", 1);
    step(); chk_probe("a_p3", 3);
    step(); chk("a_wait", {b_valid_o, busy_o}, 2'b01);
    b_ready_i = 1'b0;
    send_ack(3, 0); send_ack(0, 0); send_ack(1, 0);
    chk("a_not_yet_done", done_valid_o, 1'b0);
    step();
    chk("a_done_next", done_valid_o, 1'b1);
    finish_done("a", 4'b1011, 1'b0, 1'b0);

    // Stalled B channel holds every field; dirty ack reported.
    send_req(4'b0100, 3'd1, 4'd9, 64'h0123_4567_89AB_CDC0);
    for (int k = 0; k < 5; k++) begin
      chk_probe("b_stall", 2);
      step();
    end
    b_ready_i = 1'b1; step(); b_ready_i = 1'b0;
    chk("b_issued", b_valid_o, 1'b0);
    send_ack(2, 1'b1);
    finish_done("b", 4'b0100, 1'b1, 1'b0);

    // Empty mask goes straight to DONE with no probe.
    send_req(4'b0000, 3'd0, 4'd1, 64'h40);
    chk("c_done_1", {done_valid_o, b_valid_o, done_mask_o}, 6'b100000);
    step();
    chk("c_done_2", {done_valid_o, b_valid_o, done_mask_o}, 6'b100000);
    finish_done("c", 4'b0000, 1'b0, 1'b0);

    // Premature ack flags err, job still completes on the genuine ack.
    chk("d_err_before", err_o, 1'b0);
    send_req(4'b0100, 3'd0, 4'd3, 64'h80);
    send_ack(2, 1'b1);
    exp_err = 1'b1;
    chk("d_err_set", err_o, 1'b1);
    chk_probe("d_probe", 2);
    b_ready_i = 1'b1; step(); b_ready_i = 1'b0;
    send_ack(2, 1'b0);
    finish_done("d", 4'b0100, 1'b0, 1'b0);
    send_ack(1, 1'b0);
    chk("d_err_idle_ack", {err_o, req_ready_o}, 2'b11);

    // One ack withheld: timeout if compiled in, otherwise wait forever.
    b_ready_i = 1'b1;
    send_req(4'b0011, 3'd0, 4'd2, 64'hC0);
    step();
    b_ready_i = 1'b0;
    ack_valid_i = 1'b1; ack_client_i = 2'd0; ack_data_i = 1'b0;
    b_ready_i = 1'b1;
    step();
    ack_valid_i = 1'b0; b_ready_i = 1'b0;
    chk("e_in_wait", {b_valid_o, busy_o, done_valid_o}, 3'b010);
`ifdef TL_PROBE_TIMEOUT_EN
    n = 0;
    while (!done_valid_o && n < 40) begin step(); n++; end
    chk("e_tmo_cycles", n, 8);
    finish_done("e", 4'b0011, 1'b0, 1'b1);
`else
    for (int k = 0; k < 30; k++) step();
    chk("e_still_wait", {busy_o, done_valid_o, done_timeout_o}, 3'b100);
    send_ack(1, 1'b0);
    finish_done("e", 4'b0011, 1'b0, 1'b0);
`endif

    // Reset mid-WAIT abandons the job.
    b_ready_i = 1'b1;
    send_req(4'b0001, 3'd0, 4'd4, 64'h100);
    step();
    b_ready_i = 1'b0;
    chk("f_wait", {busy_o, b_valid_o}, 2'b10);
    rst = 1'b1; #1;
    exp_err = 1'b0;
    chk("f_rst_now", {b_valid_o, busy_o, req_ready_o, err_o}, 4'b0010);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("f_after_rst", {b_valid_o, busy_o, req_ready_o, done_valid_o}, 4'b0010);
    end

    // Randomized jobs: probes in ascending index order, acks in random order.
    for (int it = 0; it < 8; it++) begin
      m = NC'($urandom_range(1, 15));
      tq.delete();
      for (int i = 0; i < NC; i++) if (m[i]) tq.push_back(i);
      al = tq;
      send_req(m, 3'($urandom_range(0, 2)), SW'($urandom), {$urandom, $urandom});
      guard = 0;
      while (tq.size() > 0 && guard < 200) begin
        guard++;
        chk_probe("r_probe", tq[0]);
        br = 1'($urandom_range(0, 1));
        b_ready_i = br;
        step();
        if (br) void'(tq.pop_front());
      end
      b_ready_i = 1'b0;
      chk("r_all_issued", tq.size(), 0);
      exp_dirty = 1'b0;
      while (al.size() > 0) begin
        idx = $urandom_range(0, al.size() - 1);
        c = al[idx];
        al.delete(idx);
        d = 1'($urandom_range(0, 1));
        exp_dirty |= d;
        send_ack(c, d);
      end
      finish_done("r", m, exp_dirty, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tl_probe_seq.md
TL_PROBE_SEQ -- requirements
Module: tl_probe_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): N_CLIENTS, 4, probe targets; ADDR_W, 64, address width; SOURCE_W, 4, L2 source width; TIMEOUT_CYCLES, 1023, WAIT-state timeout limit; CID_W, $clog2(N_CLIENTS) (1 if N_CLIENTS=1), client-ID width.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, async active-high reset.
- req_valid_i / req_ready_o, in/out, 1, probe-job handshake.
- req_address_i, in, ADDR_W, line address.
- req_param_i, in, 3, cap param (toT=0, toB=1, toN=2).
- req_source_i, in, SOURCE_W, L2 source ID.
- req_mask_i, in, N_CLIENTS, target clients.
- b_valid_o / b_ready_i, out/in, 1, B-channel handshake toward the socket.
- b_opcode_o, out, 3, probe opcode.
- b_param_o, out, 3, probe param.
- b_size_o, out, 4, probe size.
- b_source_o, out, SOURCE_W, probe source.
- b_address_o, out, ADDR_W, probe address.
- b_dest_o, out, CID_W, destination client.
- ack_valid_i, in, 1, single-cycle pulse per completed ProbeAck/ProbeAckData.
- ack_client_i, in, CID_W, acknowledging client.
- ack_data_i, in, 1, 1 = ProbeAckData.
- done_valid_o / done_ready_i, out/in, 1, job-completion handshake.
- done_mask_o, out, N_CLIENTS, clients probed.
- done_dirty_o, out, 1, any ProbeAckData received.
- done_timeout_o, out, 1, job ended by timeout.
- err_o, out, 1, sticky unexpected-ack flag.
- busy_o, out, 1, state is not IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE; req_ready_o=1 only in IDLE.
REQ-004 On a req handshake the block SHALL latch address, param, source and mask, clear the issued and acked masks, and enter ISSUE, or enter DONE if req_mask_i=0.
REQ-005 In ISSUE, b_valid_o SHALL be 1 with b_dest_o = lowest-index target not yet issued, b_opcode_o=6 (ProbeBlock), b_size_o=6, and the other B fields taken from the latched request.
REQ-006 All B outputs SHALL be held stable while b_valid_o=1 and b_ready_i=0.
REQ-007 A B handshake SHALL set that client's issued bit; the next target SHALL be presented the following cycle, giving one probe per cycle under constant b_ready_i.
REQ-008 After the last target's B handshake the FSM SHALL enter WAIT, or DONE if all acks are already recorded.
REQ-009 In ISSUE or WAIT, an ack_valid_i whose client is issued and not yet acked SHALL set its acked bit and OR ack_data_i into the dirty flag; any other ack SHALL be ignored and set err_o.
REQ-010 An ack and a B handshake for different clients in the same cycle SHALL both be recorded.
REQ-011 The FSM SHALL go from WAIT to DONE the cycle after acked == latched mask.
REQ-012 In DONE, done_valid_o SHALL be 1 with done_mask_o = latched mask; a done handshake SHALL return the FSM to IDLE, so req_ready_o=1 on the next cycle.
REQ-013 In IDLE and DONE, ack_valid_i SHALL set err_o and change no other state.
REQ-014 err_o SHALL clear only on reset.

Reset
REQ-015 rst SHALL take effect immediately regardless of clk and force: state IDLE; all masks, flags and counters 0; b_valid_o=0; done_valid_o=0; err_o=0; busy_o=0; req_ready_o=1; all data outputs 0.
REQ-016 A reset asserted mid-job SHALL abandon the job with no B or done output after release.

Configuration
REQ-017 With TL_PROBE_TIMEOUT_EN defined, a counter SHALL run in WAIT, clear on entry to WAIT and on each accepted ack, and on reaching TIMEOUT_CYCLES force DONE with done_timeout_o=1.
REQ-018 Without TL_PROBE_TIMEOUT_EN, no counter SHALL exist, done_timeout_o SHALL be constant 0, and WAIT SHALL wait indefinitely.

Verification
REQ-019 The bench SHALL cover: mask=4'b1011, b_ready_i=1 -> probes to dest 0,1,3 on consecutive cycles; acks 3,0,1 -> done_valid_o=1 with done_mask_o=4'b1011 and done_dirty_o=0.
REQ-020 The bench SHALL cover: mask=4'b0100 with b_ready_i low for 5 cycles -> B fields constant for those 5 cycles; then an ack with ack_data_i=1 -> done_dirty_o=1.
REQ-021 The bench SHALL cover: mask=0 -> done_valid_o=1 two cycles after the req handshake with done_mask_o=0 and no b_valid_o.
REQ-022 The bench SHALL cover: ack from client 2 before its probe is issued -> err_o=1 and the job still completes after the real ack.
REQ-023 The bench SHALL cover: with TL_PROBE_TIMEOUT_EN and TIMEOUT_CYCLES=8, one ack withheld -> done_timeout_o=1 on DONE entry 8 cycles after entering WAIT.
REQ-024 The bench SHALL cover: rst asserted during WAIT -> b_valid_o=0, busy_o=0 and req_ready_o=1 immediately and after release.
